// File: rtl/axis_frame_len_stats.sv
// axis_frame_len_stats: passive AXI4-Stream frame length monitor.
// Sums per-beat byte counts (popcount of tkeep, or 1 per beat) into a
// saturating frame length. Each tlast beat produces a {len, runt, oversize}
// record, which is queued in a small first-word-fall-through FIFO.
// The module also keeps a frame counter and a drop counter.
// Optional min/max tracking is built only when AXIS_FRAME_LEN_STATS_MINMAX_EN
// is defined. Otherwise len_min is tied to all-ones and len_max to 0.
// Status handshake: a record transfers on any clock edge where status_valid
// and status_ready are both high. status_* hold steady while valid && !ready.
module axis_frame_len_stats #(
  parameter int DATA_WIDTH  = 64,
  parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = (DATA_WIDTH / 8),
  parameter int LEN_WIDTH   = 16,
  parameter int CNT_WIDTH   = 32,
  parameter int FIFO_AW     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [KEEP_WIDTH-1:0] monitor_axis_tkeep,
  input  logic                  monitor_axis_tvalid,
  input  logic                  monitor_axis_tready,
  input  logic                  monitor_axis_tlast,
  input  logic [LEN_WIDTH-1:0]  cfg_min_len,
  input  logic [LEN_WIDTH-1:0]  cfg_max_len,
  input  logic                  clear,
  output logic [LEN_WIDTH-1:0]  status_len,
  output logic                  status_runt,
  output logic                  status_oversize,
  output logic                  status_valid,
  input  logic                  status_ready,
  output logic [CNT_WIDTH-1:0]  frame_count,
  output logic [CNT_WIDTH-1:0]  drop_count,
  output logic [LEN_WIDTH-1:0]  len_min,
  output logic [LEN_WIDTH-1:0]  len_max
);

  typedef struct packed {
    logic [LEN_WIDTH-1:0] len;
    logic                 runt;
    logic                 oversize;
  } rec_t;

  localparam int DEPTH = 2 ** FIFO_AW;

  logic                 beat;
  logic                 frame_end;
  logic [LEN_WIDTH:0]   inc;
  logic [LEN_WIDTH:0]   sum;
  logic [LEN_WIDTH-1:0] base;
  logic [LEN_WIDTH-1:0] len_next;
  logic [LEN_WIDTH-1:0] acc;
  logic                 in_frame;
  rec_t                 new_rec;

  rec_t                 mem [DEPTH];
  logic [FIFO_AW:0]     wr_ptr;
  logic [FIFO_AW:0]     rd_ptr;
  logic                 empty;
  logic                 full;
  logic                 pop;
  logic                 push;
  logic                 drop;

  assign beat      = monitor_axis_tvalid && monitor_axis_tready;
  assign frame_end = beat && monitor_axis_tlast;

  // Beat increment plus saturating length for the current beat.
  always_comb begin
    inc = '0;
    if (KEEP_ENABLE != 0) begin
      for (int i = 0; i < KEEP_WIDTH; i++) begin
        inc = inc + {{LEN_WIDTH{1'b0}}, monitor_axis_tkeep[i]};
      end
    end else begin
      inc = {{LEN_WIDTH{1'b0}}, 1'b1};
    end
    base     = in_frame ? acc : '0;
    sum      = {1'b0, base} + inc;
    len_next = sum[LEN_WIDTH] ? '1 : sum[LEN_WIDTH-1:0];
    new_rec.len      = len_next;
    new_rec.runt     = (len_next < cfg_min_len);
    new_rec.oversize = (len_next > cfg_max_len);
  end

  // Accumulator and the in-frame bit. A tlast beat leaves frame start pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      in_frame <= 1'b0;
    end else if (beat) begin
      acc      <= len_next;
      in_frame <= !monitor_axis_tlast;
    end
  end

  // FIFO status. A pop in the same cycle frees a slot for an incoming record.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                 (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
  assign pop   = !empty && status_ready;
  assign push  = frame_end && (!full || pop);
  assign drop  = frame_end && full && !pop;

  // Record storage and pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[FIFO_AW-1:0]] <= new_rec;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Head record; zeros while the FIFO is empty.
  always_comb begin
    status_valid    = !empty;
    status_len      = '0;
    status_runt     = 1'b0;
    status_oversize = 1'b0;
    if (!empty) begin
      status_len      = mem[rd_ptr[FIFO_AW-1:0]].len;
      status_runt     = mem[rd_ptr[FIFO_AW-1:0]].runt;
      status_oversize = mem[rd_ptr[FIFO_AW-1:0]].oversize;
    end
  end

  // Frame counter wraps; drop counter saturates. Clear wins over a same-cycle tlast.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      frame_count <= '0;
      drop_count  <= '0;
    end else begin
      if (frame_end) begin
        frame_count <= frame_count + 1'b1;
      end
      if (drop && (drop_count != {CNT_WIDTH{1'b1}})) begin
        drop_count <= drop_count + 1'b1;
      end
    end
  end

`ifdef AXIS_FRAME_LEN_STATS_MINMAX_EN
  // Shortest and longest frame since reset or clear.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      len_min <= '1;
      len_max <= '0;
    end else if (frame_end) begin
      if (len_next < len_min) len_min <= len_next;
      if (len_next > len_max) len_max <= len_next;
    end
  end
`else
  assign len_min = '1;
  assign len_max = '0;
`endif

endmodule
